// File: rtl/load_result_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : load_result_unit                                            |
// | Purpose  : CPU load/store responder driving a 1-cycle-latency data RAM; |
// |            define MISALIGNED_EN to split misaligned accesses in two.   |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module load_result_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isLoad,
  input  logic              isStore,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   storeData,
  output logic              busy,
  output logic [XLEN-1:0]   loadResult,
  output logic              loadResultAvail,
  output logic              accessFault,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRe,
  output logic              memWe,
  output logic [3:0]        memByteEn,
  output logic [XLEN-1:0]   memWdata,
  input  logic [XLEN-1:0]   memRdata
);

`ifdef MISALIGNED_EN
  localparam logic c_MIS_EN = 1'b1;
`else
  localparam logic c_MIS_EN = 1'b0;
`endif

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_LOAD_RESP = 2'd1;
  localparam logic [1:0] c_SPLIT_LD2 = 2'd2;
  localparam logic [1:0] c_SPLIT_ST2 = 2'd3;

  logic [1:0]        r_state;
  logic              r_fault;
  logic              r_split;
  logic [1:0]        r_off;
  logic [2:0]        r_f3;
  logic [XLEN-1:0]   r_word0;
  logic [ADDR_W-1:0] r_wordAddr;
  logic [3:0]        r_hiEn;
  logic [XLEN-1:0]   r_hiData;

  logic [1:0]        w_off;
  logic [ADDR_W-1:0] w_wordAddr;
  logic [ADDR_W-1:0] w_nextAddr;
  logic              w_req;
  logic              w_badF3;
  logic              w_mis;
  logic              w_fault;
  logic              w_accept;
  logic              w_go;
  logic [3:0]        w_sizeMask;
  logic [7:0]        w_laneEn;
  logic [5:0]        w_shAmt;
  logic [2*XLEN-1:0] w_wideData;
  logic [2*XLEN-1:0] w_merged;
  logic [XLEN-1:0]   w_lane;
  logic [XLEN-1:0]   w_ext;

  assign w_off      = addr[1:0];
  assign w_wordAddr = {addr[ADDR_W-1:2], 2'b00};
  assign w_nextAddr = r_wordAddr + ADDR_W'(4);
  assign w_req      = isLoad | isStore;
  // 011/110/111 are never legal; unsigned variants make no sense for a store
  assign w_badF3    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (isStore && funct3[2]);
  assign w_mis      = ((funct3[1:0] == 2'b01) && (w_off == 2'b11)) ||
                      ((funct3[1:0] == 2'b10) && (w_off != 2'b00));
  assign w_fault    = w_req && ((isLoad && isStore) || w_badF3 || (w_mis && !c_MIS_EN));
  assign w_accept   = (r_state == c_IDLE) || (r_state == c_LOAD_RESP);
  assign w_go       = w_accept && w_req && !w_fault;

  always_comb begin
    case (funct3[1:0])
      2'b00:   w_sizeMask = 4'b0001;
      2'b01:   w_sizeMask = 4'b0011;
      default: w_sizeMask = 4'b1111;
    endcase
  end

  // Lanes and data laid out across two words; the upper word feeds the split store.
  assign w_shAmt    = {1'b0, w_off, 3'b000};
  assign w_laneEn   = {4'b0000, w_sizeMask} << w_off;
  assign w_wideData = {{XLEN{1'b0}}, storeData} << w_shAmt;

  always_comb begin
    busy      = 1'b0;
    memRe     = 1'b0;
    memWe     = 1'b0;
    memByteEn = 4'b0000;
    memWdata  = '0;
    memAddr   = w_wordAddr;
    case (r_state)
      c_IDLE, c_LOAD_RESP: begin
        if (w_go) begin
          memRe = isLoad;
          memWe = isStore;
          if (isStore) begin
            memByteEn = w_laneEn[3:0];
            memWdata  = w_wideData[XLEN-1:0];
          end
        end
      end
      c_SPLIT_LD2: begin
        busy    = 1'b1;
        memRe   = 1'b1;
        memAddr = w_nextAddr;
      end
      c_SPLIT_ST2: begin
        busy      = 1'b1;
        memWe     = 1'b1;
        memAddr   = w_nextAddr;
        memByteEn = r_hiEn;
        memWdata  = r_hiData;
      end
      default: ;
    endcase
    if (rst) begin
      busy      = 1'b0;
      memRe     = 1'b0;
      memWe     = 1'b0;
      memByteEn = 4'b0000;
    end
  end

  // An aligned result sits in the low word; a split one spans {word1, word0}.
  always_comb begin
    w_merged = r_split ? {memRdata, r_word0} : {{XLEN{1'b0}}, memRdata};
    w_lane   = w_merged[{1'b0, r_off, 3'b000} +: XLEN];
    case (r_f3)
      3'b000:  w_ext = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ext = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_lane[7:0]};
      3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_lane[15:0]};
      default: w_ext = w_lane;
    endcase
  end

  assign loadResultAvail = (r_state == c_LOAD_RESP) && !rst;
  assign loadResult      = loadResultAvail ? w_ext : '0;
  assign accessFault     = r_fault && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_fault    <= 1'b0;
      r_split    <= 1'b0;
      r_off      <= 2'b00;
      r_f3       <= 3'b000;
      r_word0    <= '0;
      r_wordAddr <= '0;
      r_hiEn     <= 4'b0000;
      r_hiData   <= '0;
    end else begin
      r_fault <= w_accept && w_fault;
      case (r_state)
        c_IDLE, c_LOAD_RESP: begin
          r_state <= c_IDLE;
          if (w_go) begin
            r_off      <= w_off;
            r_f3       <= funct3;
            r_wordAddr <= w_wordAddr;
            r_split    <= w_mis;
            r_hiEn     <= w_laneEn[7:4];
            r_hiData   <= w_wideData[2*XLEN-1:XLEN];
            if (isLoad) begin
              r_state <= w_mis ? c_SPLIT_LD2 : c_LOAD_RESP;
            end else if (w_mis) begin
              r_state <= c_SPLIT_ST2;
            end
          end
        end
        c_SPLIT_LD2: begin
          r_word0 <= memRdata;
          r_state <= c_LOAD_RESP;
        end
        c_SPLIT_ST2: r_state <= c_IDLE;
        default:     r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
